mode_shift_reg: RTL and testbench

MODE_SHIFT_REG -- requirements
Module: mode_shift_reg

---
 rtl/mode_shift_reg_pkg.sv | 19 +
 rtl/shift_step.sv | 44 ++++
 rtl/mode_shift_reg.sv | 91 +++++++++
 tb/tb_mode_shift_reg.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_shift_reg_pkg.sv
// Shared types for the mode-controlled shift register: operation codes and FSM states.
package mode_shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_LOAD = 3'd0,
    MODE_SLL  = 3'd1,
    MODE_SRL  = 3'd2,
    MODE_ROL  = 3'd3,
    MODE_ROR  = 3'd4,
    MODE_SRA  = 3'd5,
    MODE_HOLD = 3'd6
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Single-step combinational data path: moves the data by one bit and reports the expelled bit.
module shift_step
  import mode_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_mode,
  input  logic             i_fill,
  output logic [WIDTH-1:0] o_data,
  output logic             o_expelled
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    o_data     = i_data;
    o_expelled = 1'b0;
    case (mode_e'(i_mode))
      MODE_SLL: begin
        o_data     = {i_data[WIDTH-2:0], i_fill};
        o_expelled = i_data[WIDTH-1];
      end
      MODE_SRL: begin
        o_data     = {i_fill, i_data[WIDTH-1:1]};
        o_expelled = i_data[0];
      end
      MODE_ROL: begin
        o_data     = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
        o_expelled = i_data[WIDTH-1];
      end
      MODE_ROR: begin
        o_data     = {i_data[0], i_data[WIDTH-1:1]};
        o_expelled = i_data[0];
      end
      MODE_SRA: begin
        o_data     = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
        o_expelled = i_data[0];
      end
      // LOAD never reaches the stepping path; codes 6 and 7 both hold.
      default: ;
    endcase
  end

endmodule

// File: rtl/mode_shift_reg.sv
// Mode-controlled shift register: accepts an operation in IDLE, then performs
// one step per clock in SHIFT until the latched step count is exhausted.
module mode_shift_reg
  import mode_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [CNT_W-1:0] count,
  input  logic             ser_in,
  output logic [WIDTH-1:0] op,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  state_e           w_state_next;
  logic [2:0]       r_mode;
  logic [CNT_W-1:0] r_remaining;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_expelled;
  logic             w_accept_shift;
  logic             w_last_step;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_data     (op),
    .i_mode     (r_mode),
    .i_fill     (ser_in),
    .o_data     (w_step_data),
    .o_expelled (w_step_expelled)
  );

  assign w_accept_shift = start && (mode != MODE_LOAD) && (count != '0);
  assign w_last_step    = (r_remaining == CNT_W'(1));
  assign busy           = (r_state == ST_SHIFT);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept_shift) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_last_step)    w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      op          <= '0;
      ser_out     <= 1'b0;
      done        <= 1'b0;
      r_mode      <= 3'd0;
      r_remaining <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode      <= mode;
            r_remaining <= count;
            if (mode == MODE_LOAD) begin
              op   <= load_val;
              done <= 1'b1;
            end else if (count == '0) begin
              done <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          op          <= w_step_data;
          ser_out     <= w_step_expelled;
          r_remaining <= r_remaining - CNT_W'(1);
          if (w_last_step) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mode_shift_reg.sv
// Directed self-checking bench for mode_shift_reg (WIDTH=8, CNT_W=4).
module tb_mode_shift_reg;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [2:0] mode;
  logic [7:0] load_val;
  logic [3:0] count;
  logic       ser_in;
  logic [7:0] op;
  logic       ser_out;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_bad;

  mode_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .mode     (mode),
    .load_val (load_val),
    .count    (count),
    .ser_in   (ser_in),
    .op       (op),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp8(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic cmp1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic do_load(input logic [7:0] val);
    mode     = 3'd0;
    load_val = val;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    start    = 1'b1;
    mode     = 3'd0;
    load_val = 8'hFF;
    tick();
    tick();
    start = 1'b0;
    cmp8("reset_op", op, 8'h00);
    cmp1("reset_ser_out", ser_out, 1'b0);
    cmp1("reset_busy", busy, 1'b0);
    cmp1("reset_done", done, 1'b0);
  endtask

  task automatic test_load();
    mode     = 3'd0;
    load_val = 8'hA5;
    count    = 4'd7;
    start    = 1'b1;
    rstn     = 1'b1;
    tick();
    start = 1'b0;
    cmp8("load_op", op, 8'hA5);
    cmp1("load_done", done, 1'b1);
    cmp1("load_busy", busy, 1'b0);
    cmp1("load_ser_out", ser_out, 1'b0);
    tick();
    cmp1("load_done_clear", done, 1'b0);
    cmp1("load_busy_after", busy, 1'b0);
  endtask

  task automatic test_rol();
    do_load(8'h81);
    mode  = 3'd3;
    count = 4'd3;
    start = 1'b1;
    tick();
    start    = 1'b0;
    mode     = 3'd0;
    load_val = 8'hFF;
    count    = 4'd0;
    cmp1("rol_busy_accept", busy, 1'b1);
    cmp8("rol_op_accept", op, 8'h81);
    tick();
    cmp8("rol_op_s1", op, 8'h03);
    cmp1("rol_ser_s1", ser_out, 1'b1);
    cmp1("rol_busy_s1", busy, 1'b1);
    tick();
    cmp8("rol_op_s2", op, 8'h06);
    cmp1("rol_busy_s2", busy, 1'b1);
    cmp1("rol_done_s2", done, 1'b0);
    tick();
    cmp8("rol_op_s3", op, 8'h0C);
    cmp1("rol_ser_s3", ser_out, 1'b0);
    cmp1("rol_busy_s3", busy, 1'b0);
    cmp1("rol_done_s3", done, 1'b1);
    tick();
    cmp1("rol_done_clear", done, 1'b0);
  endtask

  task automatic test_sra();
    do_load(8'h80);
    mode  = 3'd5;
    count = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    cmp8("sra_op_s1", op, 8'hC0);
    tick();
    cmp8("sra_op_s2", op, 8'hE0);
    cmp1("sra_ser_out", ser_out, 1'b0);
    cmp1("sra_done", done, 1'b1);
    tick();
  endtask

  task automatic test_sll_busy_start();
    logic [7:0] exp_op [4];
    exp_op[0] = 8'h01;
    exp_op[1] = 8'h03;
    exp_op[2] = 8'h07;
    exp_op[3] = 8'h0F;
    do_load(8'h00);
    ser_in = 1'b1;
    mode   = 3'd1;
    count  = 4'd4;
    start  = 1'b1;
    tick();
    mode     = 3'd0;
    load_val = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) start = 1'b0;
      tick();
      cmp8($sformatf("sll_op_s%0d", i + 1), op, exp_op[i]);
    end
    cmp1("sll_ser_out", ser_out, 1'b0);
    cmp1("sll_done", done, 1'b1);
    tick();
    cmp8("sll_no_latent_op", op, 8'h0F);
    cmp1("sll_no_latent_busy", busy, 1'b0);
    cmp1("sll_no_latent_done", done, 1'b0);
    ser_in = 1'b0;
  endtask

  task automatic test_abort_reset();
    logic saw_activity;
    do_load(8'h01);
    mode  = 3'd4;
    count = 4'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    cmp8("ror_op_s1", op, 8'h80);
    cmp1("ror_ser_s1", ser_out, 1'b1);
    tick();
    cmp8("ror_op_s2", op, 8'h40);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    cmp8("abort_op", op, 8'h00);
    cmp1("abort_busy", busy, 1'b0);
    cmp1("abort_ser_out", ser_out, 1'b0);
    cmp1("abort_done", done, 1'b0);
    saw_activity = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) saw_activity = 1'b1;
    end
    cmp1("abort_no_late_done", saw_activity, 1'b0);
  endtask

  task automatic test_count0_back_to_back();
    do_load(8'h5A);
    mode  = 3'd2;
    count = 4'd0;
    start = 1'b1;
    tick();
    cmp1("cnt0_done", done, 1'b1);
    cmp8("cnt0_op", op, 8'h5A);
    cmp1("cnt0_busy", busy, 1'b0);
    mode  = 3'd3;
    count = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cmp1("b2b_busy", busy, 1'b1);
    cmp1("b2b_done_clear", done, 1'b0);
    tick();
    cmp8("b2b_op", op, 8'hB4);
    cmp1("b2b_ser_out", ser_out, 1'b0);
    cmp1("b2b_done", done, 1'b1);
    cmp1("b2b_busy_end", busy, 1'b0);
    tick();
  endtask

  task automatic test_max_count_hold();
    int busy_cycles;
    int guard;
    do_load(8'h3C);
    mode  = 3'd7;
    count = 4'hF;
    start = 1'b1;
    tick();
    start       = 1'b0;
    busy_cycles = 0;
    guard       = 0;
    while (busy && guard < 40) begin
      busy_cycles++;
      guard++;
      tick();
    end
    n_cmp++;
    if (busy_cycles != 15) begin
      n_bad++;
      $display("FAIL hold_busy_cycles: got %0d want %0d", busy_cycles, 15);
    end
    cmp1("hold_done", done, 1'b1);
    cmp8("hold_op", op, 8'h3C);
    cmp1("hold_ser_out", ser_out, 1'b0);
    tick();
    cmp1("hold_done_clear", done, 1'b0);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rstn     = 1'b0;
    start    = 1'b0;
    mode     = 3'd0;
    load_val = 8'h00;
    count    = 4'd0;
    ser_in   = 1'b0;
    test_reset();
    test_load();
    test_rol();
    test_sra();
    test_sll_busy_start();
    test_abort_reset();
    test_count0_back_to_back();
    test_max_count_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
